// File: rtl/fifo_burst_drainer_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fifo_burst_drainer_pkg: shared types and sizing helpers          |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package fifo_burst_drainer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  function automatic int count_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_drain_skid.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fifo_drain_skid: 2-entry registered skid buffer with occupancy   |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module fifo_drain_skid
  import fifo_burst_drainer_pkg::*;
#(
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_dat,
  input  logic                  pop,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_dat,
  output logic [1:0]            occupancy
);

  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] tail;
  logic [1:0]            occ;

  // The producer never pushes into a full buffer, and pop is only raised
  // while out_valid is high, so the overflow/underflow cases cannot occur.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      occ  <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) head <= push_dat;
          else             tail <= push_dat;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head <= tail;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            head <= push_dat;
          end else begin
            head <= tail;
            tail <= push_dat;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = (occ != 2'd0);
  assign out_dat   = head;
  assign occupancy = occ;

endmodule
`default_nettype wire

// File: rtl/fifo_burst_drainer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fifo_burst_drainer: drains the adapter FIFO in bus bursts        |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module fifo_burst_drainer
  import fifo_burst_drainer_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 4,
  parameter int BURST_LEN  = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  fifo_rd_ena,
  input  logic [DATA_WIDTH-1:0] fifo_rd_dat,
  input  logic                  fifo_rd_empty,
  input  logic [ADDR_WIDTH:0]   fifo_rd_dat_cnt,
  input  logic                  flush,
  output logic                  flush_done,
  output logic                  bus_req,
  input  logic                  bus_gnt,
  output logic [ADDR_WIDTH:0]   bus_len,
  output logic                  bus_valid,
  output logic [DATA_WIDTH-1:0] bus_dat,
  output logic                  bus_last,
  input  logic                  bus_ready,
  output logic                  busy
);

  localparam int CW = count_width(ADDR_WIDTH);
  localparam int TW = clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] BURST_MAX    = CW'(BURST_LEN);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] pop_cnt;
  logic [CW-1:0] beat_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          flush_pend;
  logic          in_flight;
  logic [1:0]    occupancy;

  logic          has_words;
  logic          full_burst;
  logic          tmo_expired;
  logic          trigger;
  logic          accept;
  logic          burst_end;
  logic [2:0]    fill;
  logic          pop_room;

  assign has_words   = (fifo_rd_dat_cnt != '0);
  assign full_burst  = (fifo_rd_dat_cnt >= BURST_MAX);
  assign tmo_expired = (tmo_cnt == TIMEOUT_LAST);
  assign trigger     = full_burst || (has_words && (tmo_expired || flush_pend));
  assign accept      = bus_valid && bus_ready;
  assign bus_last    = bus_valid && ((beat_cnt + CW'(1)) == bus_len);
  assign burst_end   = accept && bus_last;

  // Words already popped but not yet accepted must fit in the skid buffer;
  // a beat leaving this cycle frees one slot.
  assign fill     = {1'b0, occupancy} + {2'b00, in_flight};
  assign pop_room = accept ? (fill < 3'd3) : (fill < 3'd2);

  always_comb begin
    state_nxt   = state;
    fifo_rd_ena = 1'b0;
    flush_done  = 1'b0;
    bus_req     = (state == ST_REQ);
    busy        = (state != ST_IDLE);
    unique case (state)
      ST_IDLE: begin
        if (trigger)                      state_nxt  = ST_REQ;
        else if (flush_pend && !has_words) flush_done = 1'b1;
      end
      ST_REQ: begin
        if (bus_gnt) state_nxt = ST_BURST;
      end
      ST_BURST: begin
        fifo_rd_ena = (pop_cnt != bus_len) && !fifo_rd_empty && pop_room;
        if (burst_end) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      bus_len    <= '0;
      pop_cnt    <= '0;
      beat_cnt   <= '0;
      tmo_cnt    <= '0;
      flush_pend <= 1'b0;
      in_flight  <= 1'b0;
    end else begin
      state      <= state_nxt;
      in_flight  <= fifo_rd_ena;
      flush_pend <= flush || (flush_pend && !flush_done);

      if (state == ST_IDLE && has_words && !full_burst && state_nxt == ST_IDLE) begin
        if (!tmo_expired) tmo_cnt <= tmo_cnt + TW'(1);
      end else begin
        tmo_cnt <= '0;
      end

      if (state == ST_IDLE && trigger) begin
        bus_len  <= full_burst ? BURST_MAX : fifo_rd_dat_cnt;
        pop_cnt  <= '0;
        beat_cnt <= '0;
      end

      if (state == ST_BURST) begin
        if (fifo_rd_ena) pop_cnt  <= pop_cnt + CW'(1);
        if (accept)      beat_cnt <= beat_cnt + CW'(1);
        if (burst_end) begin
          bus_len  <= '0;
          pop_cnt  <= '0;
          beat_cnt <= '0;
        end
      end
    end
  end

  fifo_drain_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_flight),
    .push_dat  (fifo_rd_dat),
    .pop       (accept),
    .out_valid (bus_valid),
    .out_dat   (bus_dat),
    .occupancy (occupancy)
  );

endmodule
`default_nettype wire

// File: tb/tb_fifo_burst_drainer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_fifo_burst_drainer: directed bench with a behavioural FIFO    |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_fifo_burst_drainer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         fifo_rd_ena;
  logic [127:0] fifo_rd_dat = '0;
  logic         fifo_rd_empty;
  logic [4:0]   fifo_rd_dat_cnt;
  logic         flush = 1'b0;
  logic         flush_done;
  logic         bus_req;
  logic         bus_gnt = 1'b0;
  logic [4:0]   bus_len;
  logic         bus_valid;
  logic [127:0] bus_dat;
  logic         bus_last;
  logic         bus_ready = 1'b1;
  logic         busy;

  fifo_burst_drainer #(
    .DATA_WIDTH (128), .ADDR_WIDTH (4), .BURST_LEN (4), .TIMEOUT (64)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .fifo_rd_ena (fifo_rd_ena), .fifo_rd_dat (fifo_rd_dat),
    .fifo_rd_empty (fifo_rd_empty), .fifo_rd_dat_cnt (fifo_rd_dat_cnt),
    .flush (flush), .flush_done (flush_done),
    .bus_req (bus_req), .bus_gnt (bus_gnt), .bus_len (bus_len),
    .bus_valid (bus_valid), .bus_dat (bus_dat), .bus_last (bus_last),
    .bus_ready (bus_ready), .busy (busy)
  );

  always #5 clk = ~clk;

  // Behavioural source FIFO: read data appears the cycle after a pop.
  logic         push = 1'b0;
  logic [127:0] push_dat = '0;
  logic [127:0] fmem [16];
  int           wp = 0, rp = 0, fcnt = 0;
  always @(posedge clk) begin
    if (push) begin fmem[wp] <= push_dat; wp <= (wp + 1) % 16; end
    if (fifo_rd_ena && fcnt > 0) begin fifo_rd_dat <= fmem[rp]; rp <= (rp + 1) % 16; end
    fcnt <= fcnt + (push ? 1 : 0) - ((fifo_rd_ena && fcnt > 0) ? 1 : 0);
  end
  assign fifo_rd_empty   = (fcnt == 0);
  assign fifo_rd_dat_cnt = 5'(fcnt);

  int checks = 0, passed = 0;
  int gnt_delay = 2, req_age = 0;
  bit ready_toggle = 0;
  int word_tag = 1;

  logic [127:0] exp_dat[$];
  logic [127:0] rx_dat[$];
  bit           rx_last[$];
  int           rx_cyc[$];
  int           req_t[$];
  int           req_lenq[$];
  int cyc = 0, pops = 0, accs = 0, beat_idx = 0, len_seen = 0, req_run = 0;
  int err_empty = 0, err_fill = 0, err_popreq = 0, err_stable = 0, err_len = 0, err_last = 0;
  int n_done = 0, cnt_at_done = -1, t_cnt_nz = 0;
  logic prev_valid = 0, prev_ready = 0, prev_req = 0;
  logic [127:0] prev_dat = '0;
  logic [4:0] prev_cnt = '0;

  // Grant responder and ready pattern, updated just after each clock edge.
  initial forever begin
    @(posedge clk); #1;
    if (bus_req) req_age++; else req_age = 0;
    bus_gnt   = bus_req && (req_age >= gnt_delay);
    bus_ready = ready_toggle ? !bus_ready : 1'b1;
  end

  // Passive observer sampling at the falling edge.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      pops = 0; accs = 0; beat_idx = 0; len_seen = 0;
    end else begin
      if (!busy) beat_idx = 0;
      if (fifo_rd_ena && fifo_rd_empty) err_empty++;
      if (fifo_rd_ena && (pops - accs - ((bus_valid && bus_ready) ? 1 : 0)) >= 2) err_fill++;
      if (fifo_rd_ena && bus_req) err_popreq++;
      if (prev_valid && !prev_ready && (!bus_valid || bus_dat !== prev_dat)) err_stable++;
      if (busy) begin
        if (len_seen == 0) len_seen = int'(bus_len);
        else if (int'(bus_len) != len_seen) err_len++;
      end else len_seen = 0;
      if (bus_req) begin
        if (!prev_req) begin req_t.push_back(cyc); req_lenq.push_back(int'(bus_len)); req_run = 0; end
        req_run++;
      end
      if (bus_valid && bus_ready) begin
        beat_idx++;
        rx_dat.push_back(bus_dat); rx_last.push_back(bus_last); rx_cyc.push_back(cyc);
        if (bus_last !== (beat_idx == int'(bus_len))) err_last++;
        accs++;
      end
      if (fifo_rd_ena) pops++;
      if (flush_done) begin n_done++; cnt_at_done = int'(fifo_rd_dat_cnt); end
      if (fifo_rd_dat_cnt != 0 && prev_cnt == 0) t_cnt_nz = cyc;
    end
    prev_valid = bus_valid; prev_ready = bus_ready; prev_dat = bus_dat;
    prev_req = bus_req; prev_cnt = fifo_rd_dat_cnt;
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic clear_obs;
    exp_dat.delete(); rx_dat.delete(); rx_last.delete(); rx_cyc.delete();
    req_t.delete(); req_lenq.delete(); n_done = 0; cnt_at_done = -1;
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) begin
      push = 1'b1; push_dat = {4{32'(word_tag)}};
      exp_dat.push_back({4{32'(word_tag)}});
      word_tag++;
      tick();
    end
    push = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int b = budget;
    while (rx_dat.size() < n && b > 0) begin tick(); b--; end
    checks++;
    if (rx_dat.size() != n) $display("FAIL beat_count: got %0d required %0d", rx_dat.size(), n);
    else passed++;
  endtask

  task automatic check_data(input string name);
    int bad = 0;
    for (int i = 0; i < exp_dat.size(); i++)
      if (i >= rx_dat.size() || rx_dat[i] !== exp_dat[i]) bad++;
    checks++;
    if (bad != 0) $display("FAIL %s: %0d of %0d beats wrong", name, bad, exp_dat.size());
    else passed++;
  endtask

  task automatic check_last(input string name, input logic [7:0] required);
    logic [7:0] m = '0;
    for (int i = 0; i < rx_last.size() && i < 8; i++) m[i] = rx_last[i];
    checks++;
    if (m !== required) $display("FAIL %s: got %b required %b", name, m, required);
    else passed++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; repeat (3) tick();
    checks++; if (bus_req !== 1'b0)   $display("FAIL reset_bus_req: got %b required 0", bus_req);     else passed++;
    checks++; if (bus_valid !== 1'b0) $display("FAIL reset_bus_valid: got %b required 0", bus_valid); else passed++;
    checks++; if (busy !== 1'b0)      $display("FAIL reset_busy: got %b required 0", busy);           else passed++;
    checks++; if (fifo_rd_ena !== 1'b0) $display("FAIL reset_rd_ena: got %b required 0", fifo_rd_ena); else passed++;
    checks++; if (flush_done !== 1'b0) $display("FAIL reset_flush_done: got %b required 0", flush_done); else passed++;
    checks++; if (bus_len !== 5'd0)   $display("FAIL reset_bus_len: got %0d required 0", bus_len);    else passed++;
    checks++; if (bus_last !== 1'b0)  $display("FAIL reset_bus_last: got %b required 0", bus_last);   else passed++;
    rst_n = 1'b1; tick();
  endtask

  task automatic test_two_bursts;
    clear_obs(); gnt_delay = 2; ready_toggle = 0;
    push_words(8);
    wait_rx(8, 200);
    check_data("t1_data");
    check_last("t1_last", 8'b1000_1000);
    checks++; if (req_t.size() != 2) $display("FAIL t1_req_count: got %0d required 2", req_t.size()); else passed++;
    checks++;
    if (req_lenq.size() != 2 || req_lenq[0] != 4 || req_lenq[1] != 4)
      $display("FAIL t1_bus_len: got %0d entries, first %0d required 4,4", req_lenq.size(), (req_lenq.size() > 0) ? req_lenq[0] : -1);
    else passed++;
    checks++;
    if (rx_cyc.size() != 8 || rx_cyc[3] - rx_cyc[0] != 3 || rx_cyc[7] - rx_cyc[4] != 3)
      $display("FAIL t1_consecutive: got beat cycles size %0d required spans of 3", rx_cyc.size());
    else passed++;
    repeat (4) tick();
    checks++; if (fcnt != 0) $display("FAIL t1_fifo_empty: got %0d required 0", fcnt); else passed++;
    checks++; if (err_empty != 0) $display("FAIL t1_pop_empty: got %0d required 0", err_empty); else passed++;
  endtask

  task automatic test_timeout;
    clear_obs(); gnt_delay = 2; ready_toggle = 0;
    push_words(2);
    wait_rx(2, 200);
    checks++;
    if (req_t.size() != 1 || req_t[0] - t_cnt_nz != 64)
      $display("FAIL t2_timeout: got delay %0d (reqs %0d) required 64", (req_t.size() > 0) ? req_t[0] - t_cnt_nz : -1, req_t.size());
    else passed++;
    checks++;
    if (req_lenq.size() != 1 || req_lenq[0] != 2)
      $display("FAIL t2_bus_len: got %0d required 2", (req_lenq.size() > 0) ? req_lenq[0] : -1);
    else passed++;
    check_data("t2_data");
    check_last("t2_last", 8'b0000_0010);
    repeat (4) tick();
  endtask

  task automatic test_flush;
    int b = 300;
    clear_obs(); gnt_delay = 2; ready_toggle = 0;
    push_words(6);
    flush = 1'b1; tick(); flush = 1'b0;
    while (n_done == 0 && b > 0) begin tick(); b--; end
    repeat (10) tick();
    checks++; if (n_done != 1) $display("FAIL t3_flush_done: got %0d pulses required 1", n_done); else passed++;
    checks++; if (cnt_at_done != 0) $display("FAIL t3_cnt_at_done: got %0d required 0", cnt_at_done); else passed++;
    checks++;
    if (req_lenq.size() != 2 || req_lenq[0] != 4 || req_lenq[1] != 2)
      $display("FAIL t3_bus_len: got %0d entries, second %0d required 4,2", req_lenq.size(), (req_lenq.size() > 1) ? req_lenq[1] : -1);
    else passed++;
    checks++;
    if (req_t.size() != 2 || rx_cyc.size() < 4 || req_t[1] - rx_cyc[3] != 2)
      $display("FAIL t3_no_timeout_wait: got gap %0d required 2", (req_t.size() > 1 && rx_cyc.size() > 3) ? req_t[1] - rx_cyc[3] : -1);
    else passed++;
    checks++; if (rx_dat.size() != 6) $display("FAIL t3_beats: got %0d required 6", rx_dat.size()); else passed++;
    check_data("t3_data");
    check_last("t3_last", 8'b0010_1000);
  endtask

  task automatic test_ready_toggle;
    clear_obs(); gnt_delay = 2; ready_toggle = 1;
    push_words(4);
    wait_rx(4, 200);
    repeat (10) tick();
    ready_toggle = 0;
    checks++; if (rx_dat.size() != 4) $display("FAIL t4_no_dup: got %0d beats required 4", rx_dat.size()); else passed++;
    check_data("t4_data");
    check_last("t4_last", 8'b0000_1000);
    checks++; if (err_fill != 0) $display("FAIL t4_pop_rule: got %0d violations required 0", err_fill); else passed++;
    checks++; if (err_stable != 0) $display("FAIL t4_stable: got %0d violations required 0", err_stable); else passed++;
    checks++; if (err_last != 0) $display("FAIL t4_last_pos: got %0d violations required 0", err_last); else passed++;
  endtask

  task automatic test_grant_delay;
    clear_obs(); gnt_delay = 10; ready_toggle = 0;
    push_words(4);
    wait_rx(4, 200);
    checks++; if (req_run != 10) $display("FAIL t5_req_hold: got %0d cycles required 10", req_run); else passed++;
    checks++; if (err_popreq != 0) $display("FAIL t5_pop_before_gnt: got %0d required 0", err_popreq); else passed++;
    checks++; if (err_len != 0) $display("FAIL t5_len_stable: got %0d violations required 0", err_len); else passed++;
    checks++;
    if (req_lenq.size() != 1 || req_lenq[0] != 4)
      $display("FAIL t5_bus_len: got %0d required 4", (req_lenq.size() > 0) ? req_lenq[0] : -1);
    else passed++;
    check_data("t5_data");
    gnt_delay = 2;
    repeat (4) tick();
  endtask

  task automatic test_reset_mid_burst;
    int b = 200;
    clear_obs(); gnt_delay = 2; ready_toggle = 0;
    push_words(4);
    while (rx_dat.size() < 1 && b > 0) begin tick(); b--; end
    flush = 1'b1; tick(); flush = 1'b0;
    while (rx_dat.size() < 2 && b > 0) begin tick(); b--; end
    checks++; if (rx_dat.size() != 2) $display("FAIL t6_two_beats: got %0d required 2", rx_dat.size()); else passed++;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    checks++; if (busy !== 1'b0) $display("FAIL t6_busy: got %b required 0", busy); else passed++;
    checks++; if (bus_valid !== 1'b0) $display("FAIL t6_bus_valid: got %b required 0", bus_valid); else passed++;
    checks++; if (bus_req !== 1'b0) $display("FAIL t6_bus_req: got %b required 0", bus_req); else passed++;
    checks++; if (fifo_rd_ena !== 1'b0) $display("FAIL t6_rd_ena: got %b required 0", fifo_rd_ena); else passed++;
    checks++; if (bus_len !== 5'd0) $display("FAIL t6_bus_len: got %0d required 0", bus_len); else passed++;
    repeat (20) tick();
    checks++; if (n_done != 0) $display("FAIL t6_flush_pend_cleared: got %0d done pulses required 0", n_done); else passed++;
    checks++; if (req_t.size() != 1) $display("FAIL t6_no_new_req: got %0d requests required 1", req_t.size()); else passed++;
  endtask

  initial begin
    test_reset();
    test_two_bursts();
    test_timeout();
    test_flush();
    test_ready_toggle();
    test_grant_delay();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $display("%0d/%0d checks passed", passed, checks + 1);
    $fatal(1);
  end

endmodule
`default_nettype wire
